// File: rtl/k12a_spi_pkg.sv
// Shared types and constants for the k12a SPI blocks.
package k12a_spi_pkg;

  typedef enum logic {
    SPI_TGT_IDLE,
    SPI_TGT_SELECTED
  } spi_tgt_state_t;

  localparam int SPI_BITS_PER_BYTE = 8;
  localparam logic [7:0] SPI_IDLE_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/k12a_sync2.sv
// Two-flop synchronizer for one asynchronous input pin.
// Latency 2 cycles; RST_VAL is the pin's idle level so reset never creates an edge.
module k12a_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic cpu_clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/k12a_spi_target.sv
// SPI mode-0 target with oversampled pins; pin-to-event latency 2-3 cpu_clock cycles.
// TX: 1-entry holding register (tx_ready when empty); RX: full RX drops bytes and flags overrun.
// K12A_SPI_TARGET_RX_FIFO_EN selects an RX_DEPTH-entry RX FIFO instead of a single register.
module k12a_spi_target
  import k12a_spi_pkg::*;
#(
  parameter int         RX_DEPTH  = 4,
  parameter logic [7:0] IDLE_BYTE = SPI_IDLE_BYTE_DEFAULT
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       spi_ss_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       underrun
);

  // Occupancy counter is sized for the largest configuration.
  localparam int CNT_W = $clog2(RX_DEPTH + 1);
`ifdef K12A_SPI_TARGET_RX_FIFO_EN
  localparam int RX_CAP = RX_DEPTH;
  localparam int PTR_W  = $clog2(RX_DEPTH);
`else
  localparam int RX_CAP = 1;
`endif

  logic ss_s, sck_s, mosi_s;

  k12a_sync2 #(.RST_VAL(1'b1)) u_sync_ss   (.cpu_clock, .reset_n, .d(spi_ss_n), .q(ss_s));
  k12a_sync2 #(.RST_VAL(1'b0)) u_sync_sck  (.cpu_clock, .reset_n, .d(spi_sck),  .q(sck_s));
  k12a_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.cpu_clock, .reset_n, .d(spi_mosi), .q(mosi_s));

  spi_tgt_state_t   state_q, state_d;
  logic             sck_prev_q, sck_prev_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             byte_end_q, byte_end_d;
  logic [6:0]       tx_shift_q, tx_shift_d;
  logic [6:0]       rx_shift_q, rx_shift_d;
  logic             miso_q, miso_d;
  logic             hold_vld_q, hold_vld_d;
  logic [7:0]       hold_dat_q, hold_dat_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;

  logic       selected, sck_rise, sck_fall, tx_load;
  logic       rx_push, rx_pop, rx_full, rx_accept;
  logic [7:0] rx_byte, tx_next;

  assign selected  = (state_q == SPI_TGT_SELECTED) && !ss_s;
  assign sck_rise  = selected && sck_s && !sck_prev_q;
  assign sck_fall  = selected && !sck_s && sck_prev_q;
  assign tx_load   = ((state_q == SPI_TGT_IDLE) && !ss_s) || (sck_fall && byte_end_q);
  assign tx_next   = hold_vld_q ? hold_dat_q : IDLE_BYTE;
  assign rx_byte   = {rx_shift_q, mosi_s};
  assign rx_push   = sck_rise && (bit_cnt_q == 3'(SPI_BITS_PER_BYTE - 1));
  assign rx_valid  = (rx_cnt_q != '0);
  assign rx_full   = (rx_cnt_q == CNT_W'(RX_CAP));
  assign rx_pop    = rx_valid && rx_ready;
  assign rx_accept = rx_push && (!rx_full || rx_pop);

  // A register being copied out this cycle can take a new byte at the same time.
  assign tx_ready  = !hold_vld_q || tx_load;
  assign spi_miso  = miso_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;

  always_comb begin
    state_d    = state_q;
    sck_prev_d = sck_s;
    bit_cnt_d  = bit_cnt_q;
    byte_end_d = byte_end_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(rx_accept) - CNT_W'(rx_pop);
    case (state_q)
      SPI_TGT_IDLE: begin
        miso_d = 1'b1;
        if (!ss_s) begin
          state_d              = SPI_TGT_SELECTED;
          {miso_d, tx_shift_d} = tx_next;
          if (!hold_vld_q) underrun_d = 1'b1;
        end
      end
      default: begin
        if (ss_s) begin
          state_d    = SPI_TGT_IDLE;
          bit_cnt_d  = 3'd0;
          byte_end_d = 1'b0;
          miso_d     = 1'b1;
          overrun_d  = 1'b0;
          underrun_d = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = rx_byte[6:0];
          bit_cnt_d  = bit_cnt_q + 3'd1;
          byte_end_d = rx_push;
          if (rx_push && !rx_accept) overrun_d = 1'b1;
        end else if (sck_fall) begin
          byte_end_d = 1'b0;
          if (byte_end_q) begin
            {miso_d, tx_shift_d} = tx_next;
            if (!hold_vld_q) underrun_d = 1'b1;
          end else begin
            miso_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
          end
        end
      end
    endcase
    if (tx_load) hold_vld_d = 1'b0;
    if (tx_valid && tx_ready) begin
      hold_vld_d = 1'b1;
      hold_dat_d = tx_data;
    end
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SPI_TGT_IDLE;
      sck_prev_q <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_end_q <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso_q     <= 1'b1;
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      sck_prev_q <= sck_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_end_q <= byte_end_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      miso_q     <= miso_d;
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

`ifdef K12A_SPI_TARGET_RX_FIFO_EN
  logic [7:0]       mem_q [RX_DEPTH];
  logic [7:0]       mem_d [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // Pointers wrap naturally because RX_DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rx_accept) begin
      mem_d[wr_ptr_q] = rx_byte;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rx_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rx_data = mem_q[rd_ptr_q];
`else
  logic [7:0] rx_dat_q, rx_dat_d;

  always_comb begin
    rx_dat_d = rx_dat_q;
    if (rx_accept) rx_dat_d = rx_byte;
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) rx_dat_q <= '0;
    else          rx_dat_q <= rx_dat_d;
  end

  assign rx_data = rx_dat_q;
`endif

endmodule

// File: tb/tb_k12a_spi_target.sv
// Directed and randomized bench for k12a_spi_target acting as an SPI master at cpu_clock:SCK = 8:1.
`timescale 1ns/1ps
module tb_k12a_spi_target;

  localparam int RX_DEPTH = 4;
`ifdef K12A_SPI_TARGET_RX_FIFO_EN
  localparam int RX_CAP = RX_DEPTH;
`else
  localparam int RX_CAP = 1;
`endif

  logic       cpu_clock = 1'b0;
  logic       reset_n   = 1'b0;
  logic       spi_ss_n  = 1'b1;
  logic       spi_sck   = 1'b0;
  logic       spi_mosi  = 1'b0;
  logic       spi_miso;
  logic [7:0] tx_data   = 8'h00;
  logic       tx_valid  = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready  = 1'b0;
  logic       overrun;
  logic       underrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mo_arr [4];
  logic [7:0] tx_arr [4];
  logic [7:0] exp_miso [4];
  logic [7:0] rx_model [$];

  always #5 cpu_clock = ~cpu_clock;

  k12a_spi_target #(.RX_DEPTH(RX_DEPTH), .IDLE_BYTE(8'hFF)) dut (
    .cpu_clock(cpu_clock), .reset_n(reset_n),
    .spi_ss_n(spi_ss_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .underrun(underrun)
  );

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge cpu_clock);
  endtask

  task automatic select_tgt();
    spi_ss_n = 1'b0;
    cyc(8);
  endtask

  task automatic deselect_tgt();
    cyc(4);
    spi_ss_n = 1'b1;
    cyc(8);
  endtask

  // Mode 0: master changes MOSI while SCK is low and samples MISO on the rising edge.
  task automatic xfer_bits(input logic [7:0] m, input int nbits, input bit pop_last,
                           output logic [7:0] s);
    s = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = m[7-i];
      cyc(4);
      spi_sck = 1'b1;
      s = {s[6:0], spi_miso};
      if (pop_last && i == 7) begin
        cyc(2);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        cyc(1);
      end else begin
        cyc(4);
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (tx_ready) break;
      cyc(1);
    end
    chk1("tx_push_ready", tx_ready, 1'b1);
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk1({tag, "_vld"}, rx_valid, 1'b1);
    chk8({tag, "_dat"}, rx_data, exp);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    logic [7:0] b;
    int         nb;
    bit         preload;

    // Reset values
    cyc(3);
    chk1("rst_miso", spi_miso, 1'b1);
    chk1("rst_tx_ready", tx_ready, 1'b1);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    reset_n = 1'b1;
    cyc(4);
    chk1("idle_miso", spi_miso, 1'b1);

    // Single byte with preloaded TX
    push_tx(8'h3C);
    chk1("hold_full_not_ready", tx_ready, 1'b0);
    select_tgt();
    chk1("sel_underrun_clear", underrun, 1'b0);
    xfer_bits(8'hA5, 8, 1'b0, s);
    chk8("single_miso", s, 8'h3C);
    cyc(2);
    chk1("single_rx_valid", rx_valid, 1'b1);
    chk8("single_rx_data", rx_data, 8'hA5);
    deselect_tgt();
    chk1("single_miso_idle", spi_miso, 1'b1);
    pop_check("single_pop", 8'hA5);
    chk1("single_rx_empty", rx_valid, 1'b0);

    // No TX data available
    select_tgt();
    chk1("notx_underrun_sel", underrun, 1'b1);
    xfer_bits(8'h00, 8, 1'b0, s);
    chk8("notx_miso", s, 8'hFF);
    deselect_tgt();
    chk1("notx_underrun_clr", underrun, 1'b0);
    pop_check("notx_pop", 8'h00);

    // Randomized multi-byte sessions
    rx_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      nb      = $urandom_range(1, 4);
      preload = ($urandom_range(0, 1) == 1);
      for (int j = 0; j < 4; j++) begin
        mo_arr[j]   = 8'($urandom);
        tx_arr[j]   = 8'($urandom);
        exp_miso[j] = tx_arr[j];
      end
      if (!preload) exp_miso[0] = 8'hFF;
      if (preload) push_tx(tx_arr[0]);
      fork
        begin
          cyc(6);
          for (int j = 1; j < nb; j++) push_tx(tx_arr[j]);
        end
        begin
          select_tgt();
          chk1("rnd_underrun_sel", underrun, !preload);
          for (int j = 0; j < nb; j++) begin
            xfer_bits(mo_arr[j], 8, 1'b0, s);
            chk8("rnd_miso", s, exp_miso[j]);
          end
          cyc(2);
          chk1("rnd_overrun", overrun, 1'b0);
          deselect_tgt();
        end
        begin
          for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < 400; k++) begin
              if (rx_valid) break;
              cyc(1);
            end
            chk1("rnd_rx_valid", rx_valid, 1'b1);
            chk8("rnd_rx_data", rx_data, mo_arr[j]);
            cyc(1);
          end
        end
      join
    end
    rx_ready = 1'b0;
    cyc(2);
    chk1("rnd_rx_drained", rx_valid, 1'b0);

    // Overrun: one byte more than RX can hold
    rx_model.delete();
    select_tgt();
    for (int j = 0; j <= RX_CAP; j++) begin
      b = 8'($urandom);
      if (j < RX_CAP) rx_model.push_back(b);
      xfer_bits(b, 8, 1'b0, s);
      cyc(2);
      if (j == RX_CAP - 1) chk1("ovr_not_yet", overrun, 1'b0);
    end
    chk1("ovr_set", overrun, 1'b1);
    chk1("ovr_rx_valid", rx_valid, 1'b1);
    deselect_tgt();
    chk1("ovr_clr_on_ss", overrun, 1'b0);
    while (rx_model.size() > 0) pop_check("ovr_keep", rx_model.pop_front());
    chk1("ovr_extra_lost", rx_valid, 1'b0);

    // Abort: partial byte of ones then a full 8'h81
    select_tgt();
    xfer_bits(8'hFF, 5, 1'b0, s);
    deselect_tgt();
    chk1("abort_no_partial", rx_valid, 1'b0);
    select_tgt();
    xfer_bits(8'h81, 8, 1'b0, s);
    deselect_tgt();
    pop_check("abort_rx", 8'h81);
    chk1("abort_only_one", rx_valid, 1'b0);

    // Pop in the same cycle a byte completes into a full RX
    rx_model.delete();
    select_tgt();
    for (int j = 0; j < RX_CAP; j++) begin
      b = 8'($urandom);
      rx_model.push_back(b);
      xfer_bits(b, 8, 1'b0, s);
    end
    cyc(2);
    chk1("pop_same_full", overrun, 1'b0);
    b = 8'($urandom);
    void'(rx_model.pop_front());
    rx_model.push_back(b);
    xfer_bits(b, 8, 1'b1, s);
    cyc(2);
    chk1("pop_same_no_ovr", overrun, 1'b0);
    deselect_tgt();
    while (rx_model.size() > 0) pop_check("pop_same_rx", rx_model.pop_front());
    chk1("pop_same_empty", rx_valid, 1'b0);

    // Reset asserted mid-byte with RX and TX holding data
    push_tx(8'($urandom));
    select_tgt();
    xfer_bits(8'h5A, 8, 1'b0, s);
    push_tx(8'h77);
    xfer_bits(8'hC3, 3, 1'b0, s);
    cyc(1);
    chk1("pre_rst_rx_valid", rx_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_miso", spi_miso, 1'b1);
    chk1("mid_rst_tx_ready", tx_ready, 1'b1);
    chk1("mid_rst_rx_valid", rx_valid, 1'b0);
    chk8("mid_rst_rx_data", rx_data, 8'h00);
    chk1("mid_rst_overrun", overrun, 1'b0);
    chk1("mid_rst_underrun", underrun, 1'b0);
    spi_ss_n = 1'b1;
    spi_sck  = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(4);
    b = 8'($urandom);
    push_tx(8'h96);
    select_tgt();
    xfer_bits(b, 8, 1'b0, s);
    chk8("post_rst_miso", s, 8'h96);
    deselect_tgt();
    pop_check("post_rst_rx", b);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
